// File: rtl/motor_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : motor_ramp
//  Purpose  : Slew-rate limiter and direction sequencer placed in front of
//             motor_controller. Accepts speed commands over a valid/ready
//             handshake and walks the duty output toward the commanded value
//             by at most STEP_SIZE per ramp tick. A direction reversal first
//             brakes duty to zero, optionally holds a dead interval, and only
//             then flips the direction output.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STEP_DIV   : clock cycles per ramp tick (>= 2)
//    STEP_SIZE  : maximum duty change per tick (1..1023)
//    DEAD_TICKS : ticks held at zero duty before a direction flip (>= 1)
//  Ports
//    CLOCK_50   in   system clock, rising edge
//    reset_n    in   asynchronous active-low reset (emergency stop)
//    cmd_valid  in   command present
//    cmd_ready  out  command can be accepted
//    cmd_dir    in   requested direction
//    cmd_duty   in   requested duty [9:0]
//    cmd_enable in   requested enable, 0 ramps to stop
//    dir        out  direction to motor_controller
//    enable     out  enable to motor_controller
//    duty       out  duty [9:0] to motor_controller
//    at_target  out  duty and direction have reached the effective target
//  Build option
//    MOTOR_RAMP_DEADTIME_EN : when defined, a DEAD state holds zero duty for
//                             DEAD_TICKS ticks before the direction flips and
//                             cmd_ready is low during that interval. When not
//                             defined the flip happens on the tick that duty
//                             reaches zero and cmd_ready is tied high.
// ============================================================================
module motor_ramp #(
    parameter int STEP_DIV   = 50000,
    parameter int STEP_SIZE  = 8,
    parameter int DEAD_TICKS = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [9:0] cmd_duty,
    input  logic       cmd_enable,
    output logic       dir,
    output logic       enable,
    output logic [9:0] duty,
    output logic       at_target
);

    localparam int              PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [10:0]     STEP     = 11'(STEP_SIZE);

`ifdef MOTOR_RAMP_DEADTIME_EN
    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_BRAKE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam int               DEAD_W    = $clog2(DEAD_TICKS + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TICKS);

    logic [DEAD_W-1:0] dead_cnt;
`else
    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_BRAKE = 2'd1
    } state_t;
`endif

    state_t            state;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic              accept;
    logic              tgt_dir;
    logic              tgt_en;
    logic [9:0]        tgt_duty;
    logic [9:0]        eff;
    logic [10:0]       duty_x;
    logic [10:0]       eff_x;
    logic [9:0]        brake_duty;
    logic [9:0]        toward_duty;

`ifdef MOTOR_RAMP_DEADTIME_EN
    logic              ready_q;
    assign cmd_ready = ready_q;
`else
    assign cmd_ready = 1'b1;
`endif

    assign tick   = (pre_cnt == PRE_LAST);
    assign accept = cmd_valid & cmd_ready;
    assign eff    = tgt_en ? tgt_duty : 10'd0;

    // 11-bit working copies so differences and sums never wrap.
    assign duty_x = {1'b0, duty};
    assign eff_x  = {1'b0, eff};

    // Braking step, saturating at zero.
    assign brake_duty = (duty_x > STEP) ? 10'(duty_x - STEP) : 10'd0;

    // Tracking step: land exactly on the target when it is within one step.
    assign toward_duty = (eff_x > duty_x)
                       ? (((eff_x - duty_x) > STEP) ? 10'(duty_x + STEP) : eff)
                       : (((duty_x - eff_x) > STEP) ? 10'(duty_x - STEP) : eff);

    // Decoded from registers only, so there is no input-to-output path.
    assign enable    = (duty != 10'd0) | (tgt_en & (state == ST_TRACK));
    assign at_target = (duty == eff) & (dir == tgt_dir) & (state == ST_TRACK);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_TRACK;
            pre_cnt  <= '0;
            tgt_dir  <= 1'b0;
            tgt_en   <= 1'b0;
            tgt_duty <= 10'd0;
            dir      <= 1'b0;
            duty     <= 10'd0;
`ifdef MOTOR_RAMP_DEADTIME_EN
            dead_cnt <= '0;
            ready_q  <= 1'b1;
`endif
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);

            // Targets load independently of the tick; a tick on the same edge
            // still sees the previous targets through the NBA semantics.
            if (accept) begin
                tgt_dir  <= cmd_dir;
                tgt_duty <= cmd_duty;
                tgt_en   <= cmd_enable;
            end

            if (tick) begin
                case (state)
                    ST_TRACK: begin
                        if (dir != tgt_dir) begin
                            if (duty == 10'd0) begin
`ifdef MOTOR_RAMP_DEADTIME_EN
                                state    <= ST_DEAD;
                                dead_cnt <= DEAD_LOAD;
                                ready_q  <= 1'b0;
`else
                                dir      <= tgt_dir;
`endif
                            end else begin
                                duty  <= brake_duty;
                                state <= ST_BRAKE;
                            end
                        end else begin
                            duty <= toward_duty;
                        end
                    end

                    ST_BRAKE: begin
                        if (dir == tgt_dir) begin
                            // Reversal aborted: resume tracking on this tick.
                            duty  <= toward_duty;
                            state <= ST_TRACK;
                        end else begin
                            duty <= brake_duty;
                            if (brake_duty == 10'd0) begin
`ifdef MOTOR_RAMP_DEADTIME_EN
                                state    <= ST_DEAD;
                                dead_cnt <= DEAD_LOAD;
                                ready_q  <= 1'b0;
`else
                                dir      <= tgt_dir;
                                state    <= ST_TRACK;
`endif
                            end
                        end
                    end

`ifdef MOTOR_RAMP_DEADTIME_EN
                    ST_DEAD: begin
                        duty <= 10'd0;
                        if (dead_cnt <= DEAD_W'(1)) begin
                            dead_cnt <= '0;
                            dir      <= tgt_dir;
                            state    <= ST_TRACK;
                            ready_q  <= 1'b1;
                        end else begin
                            dead_cnt <= dead_cnt - DEAD_W'(1);
                        end
                    end
`endif

                    default: begin
                        state <= ST_TRACK;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
